sha256_wb_master: RTL and testbench
===================================

// Module: sha256_wb_master
// PURPOSE
//  Wishbone classic master that drives the memory-mapped SHA-256 peripheral: accepts a 512-bit block,
//  polls core ready, writes 16 block words, pulses init/next, polls digest_valid, reads back 8 digest words.
//  Sits between a local block producer (DMA/CPU-less datapath) and the SHA-256 slave on the bus.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte base address of the SHA-256 slave
//  POLL_GAP    2              idle cycles between consecutive poll reads (0..255)
//  SETTLE_CYC  4              idle cycles after control write before first digest_valid poll (1..255)
//  TIMEOUT     4096           max poll reads per poll loop (used only with SHA_WBM_TIMEOUT_EN)
// PORTS
//  wb_clk_i     in   1    clock
//  wb_rst_i     in   1    reset, asynchronous, active-low
//  cmd_valid    in   1    block command valid
//  cmd_ready    out  1    high only in IDLE; handshake = cmd_valid & cmd_ready
//  cmd_next     in   1    0: init (ctrl write 32'h1), 1: next (ctrl write 32'h2)
//  cmd_block    in   512  message block; word i = cmd_block[32i+31:32i]
//  rsp_valid    out  1    result valid, held until rsp_ready
//  rsp_ready    in   1    result accept
//  rsp_digest   out  256  digest; word k = rsp_digest[32k+31:32k]
//  rsp_err      out  1    bus error or poll timeout; qualifies rsp_valid
//  busy         out  1    ~IDLE
//  wb_adr_o     out  32   bus address
//  wb_dat_o     out  32   write data
//  wb_sel_o     out  4    constant 4'hF
//  wb_we_o      out  1    write enable
//  wb_cyc_o     out  1    cycle
//  wb_stb_o     out  1    strobe (always equal to wb_cyc_o)
//  wb_dat_i     in   32   read data
//  wb_ack_i     in   1    transfer ack
//  wb_err_i     in   1    transfer error
// BEHAVIOUR
//  - Reset: all outputs 0 (cmd_ready 0 during reset, 1 one cycle after release), state IDLE, regs cleared.
//    Reset mid-operation aborts immediately; cyc/stb drop asynchronously; no response produced.
//  - Bus: single classic transfers; cyc/stb/adr/dat/we registered, held stable until ack or err sampled;
//    cyc/stb deasserted the cycle after ack/err; >=1 idle cycle between transfers (2 cycles min per transfer).
//    ack and err same cycle: err wins.
//  - Command handshake in IDLE latches cmd_block and cmd_next into internal regs; input may change after.
//  - FSM: IDLE -> CHK_RDY -> WR_BLK -> WR_CTL -> SETTLE -> POLL -> RD_DIG -> RESP -> IDLE.
//    CHK_RDY: read BASE+0x00; bit0=1 -> WR_BLK, else wait POLL_GAP cycles, reread.
//    WR_BLK: 16 writes, i=0..15 ascending, addr BASE+4*(i+1), data word i.
//    WR_CTL: write BASE+0x00 with 32'h1 (init) or 32'h2 (next); exactly one write per command.
//    SETTLE: SETTLE_CYC idle cycles (stale digest_valid clears in slave).
//    POLL: read BASE+0x44; bit0=1 -> RD_DIG, else wait POLL_GAP, reread.
//    RD_DIG: 8 reads k=0..7, addr BASE+0x48+4k, into rsp_digest[32k+31:32k].
//    RESP: rsp_valid=1, rsp_digest/rsp_err stable until rsp_ready sampled high; then IDLE.
//  - wb_err_i on any transfer: abort sequence, -> RESP with rsp_err=1, rsp_digest=0; no further transfers.
//  - Only bit0 of poll reads is examined; other bits ignored. Address arithmetic wraps mod 2^32.
//  - cmd_valid ignored outside IDLE; rsp_ready ignored outside RESP.
// CONFIGURATION
//  SHA_WBM_TIMEOUT_EN defined: 16-bit poll counter, cleared on entry to CHK_RDY and POLL; after TIMEOUT
//    reads without bit0=1 -> RESP with rsp_err=1, rsp_digest=0.
//  Not defined: counter absent; CHK_RDY/POLL loop indefinitely; rsp_err only from wb_err_i.
// TESTING
//  1. cmd_next=0, block[511:480]=32'h61626380, block[31:0]=32'h18, rest 0, with real slave+core ->
//     writes to 0x04..0x40 then 0x00=32'h1; rsp_digest=256'hba7816bf..f20015ad (SHA-256 "abc"), rsp_err=0.
//  2. Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": init then cmd_next=1 ->
//     second ctrl write 32'h2; final rsp_digest=256'h248d6a61..19db06c1, rsp_err=0.
//  3. Slave model delays ack 3 cycles per transfer and rsp_ready low 10 cycles -> bus outputs stable until
//     ack; rsp_valid/rsp_digest stable, cmd_ready=0 while pending; digest still correct.
//  4. wb_err_i on 5th block write (addr 0x14) -> cyc/stb 0 next cycle, rsp_valid=1, rsp_err=1,
//     rsp_digest=0, no write to 0x00 issued.
//  5. With SHA_WBM_TIMEOUT_EN, TIMEOUT=16, slave digest_valid stuck 0 -> exactly 16 reads of 0x44, then
//     rsp_err=1; without macro, polling continues past 1000 reads with no response.
//  6. Assert wb_rst_i=0 mid WR_BLK -> cyc/stb/rsp_valid 0 in same cycle; after release, command 1 repeats
//     correctly with rsp_digest matching.

Source files
------------

// File: rtl/sha256_wb_master.sv
// sha256_wb_master: Wishbone classic master sequencing one SHA-256 block
// through the memory-mapped hash peripheral (ready poll, block write,
// init/next control write, digest_valid poll, digest read-back).
// Optional build macro SHA_WBM_TIMEOUT_EN adds a bounded poll counter that
// turns a stuck ready/digest_valid bit into an error response.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a block command, cmd_ready high
// S_CHK_RDY | polling BASE+0x00 until core ready (bit0)
// S_WR_BLK  | writing block words 0..15 to BASE+0x04..0x40
// S_WR_CTL  | single control write, 1 = init, 2 = next
// S_SETTLE  | idle gap so the slave clears a stale digest_valid
// S_POLL    | polling BASE+0x44 until digest_valid (bit0)
// S_RD_DIG  | reading digest words 0..7 from BASE+0x48..0x64
// S_RESP    | presenting the result until rsp_ready
module sha256_wb_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          POLL_GAP   = 2,
    parameter int          SETTLE_CYC = 4,
    parameter int          TIMEOUT    = 4096
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_next,
    input  logic [511:0] cmd_block,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_digest,
    output logic         rsp_err,
    output logic         busy,
    output logic [31:0]  wb_adr_o,
    output logic [31:0]  wb_dat_o,
    output logic [3:0]   wb_sel_o,
    output logic         wb_we_o,
    output logic         wb_cyc_o,
    output logic         wb_stb_o,
    input  logic [31:0]  wb_dat_i,
    input  logic         wb_ack_i,
    input  logic         wb_err_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHK_RDY, S_WR_BLK, S_WR_CTL, S_SETTLE, S_POLL, S_RD_DIG, S_RESP
    } state_t;

    // The cycle after ack/err is always idle, so the gap counter only
    // supplies the idle cycles beyond that first one.
    localparam logic [7:0] GAP_LOAD    = (POLL_GAP > 1) ? 8'(POLL_GAP - 1) : 8'd0;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    state_t         state_q, state_d;
    logic           cyc_q, cyc_d;
    logic           we_q, we_d;
    logic [31:0]    adr_q, adr_d;
    logic [31:0]    dat_q, dat_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     wait_q, wait_d;
    logic [511:0]   blk_q, blk_d;
    logic           nxt_q, nxt_d;
    logic [255:0]   dig_q, dig_d;
    logic           err_q, err_d;
    logic           rdy_q, rdy_d;
    logic           xfer_ok;
`ifdef SHA_WBM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    logic [15:0]    poll_q, poll_d;
`endif

    assign cmd_ready  = rdy_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);
    assign rsp_digest = dig_q;
    assign rsp_err    = err_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = 4'hF;
    assign wb_we_o    = we_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign xfer_ok    = cyc_q & wb_ack_i & ~wb_err_i;

    // Next-state and bus/datapath register updates.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        blk_d   = blk_q;
        nxt_d   = nxt_q;
        dig_d   = dig_q;
        err_d   = err_q;
`ifdef SHA_WBM_TIMEOUT_EN
        poll_d  = poll_q;
`endif
        if (cyc_q && (wb_ack_i || wb_err_i)) cyc_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && rdy_q) begin
                    blk_d   = cmd_block;
                    nxt_d   = cmd_next;
                    dig_d   = '0;
                    err_d   = 1'b0;
                    idx_d   = 4'd0;
                    wait_d  = 8'd0;
`ifdef SHA_WBM_TIMEOUT_EN
                    poll_d  = 16'd0;
`endif
                    state_d = S_CHK_RDY;
                end
            end
            S_CHK_RDY, S_POLL: begin
                if (!cyc_q) begin
                    if (wait_q != 8'd0) begin
                        wait_d = wait_q - 8'd1;
                    end else begin
                        cyc_d = 1'b1;
                        we_d  = 1'b0;
                        adr_d = BASE_ADDR + ((state_q == S_POLL) ? 32'h44 : 32'h0);
                    end
                end else if (xfer_ok) begin
                    if (wb_dat_i[0]) begin
                        idx_d   = 4'd0;
                        state_d = (state_q == S_POLL) ? S_RD_DIG : S_WR_BLK;
                    end else begin
                        wait_d = GAP_LOAD;
`ifdef SHA_WBM_TIMEOUT_EN
                        poll_d = poll_q + 16'd1;
                        if (poll_q == TIMEOUT_CNT - 16'd1) begin
                            err_d   = 1'b1;
                            dig_d   = '0;
                            state_d = S_RESP;
                        end
`endif
                    end
                end
            end
            S_WR_BLK: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = BASE_ADDR + 32'h4 + {26'd0, idx_q, 2'b00};
                    dat_d = blk_q[32*idx_q +: 32];
                end else if (xfer_ok) begin
                    if (idx_q == 4'd15) state_d = S_WR_CTL;
                    else                idx_d   = idx_q + 4'd1;
                end
            end
            S_WR_CTL: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = BASE_ADDR;
                    dat_d = nxt_q ? 32'h2 : 32'h1;
                end else if (xfer_ok) begin
                    wait_d  = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (wait_q != 8'd0) begin
                    wait_d = wait_q - 8'd1;
                end else begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = BASE_ADDR + 32'h44;
`ifdef SHA_WBM_TIMEOUT_EN
                    poll_d  = 16'd0;
`endif
                    state_d = S_POLL;
                end
            end
            S_RD_DIG: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = BASE_ADDR + 32'h48 + {27'd0, idx_q[2:0], 2'b00};
                end else if (xfer_ok) begin
                    dig_d[32*idx_q[2:0] +: 32] = wb_dat_i;
                    if (idx_q == 4'd7) state_d = S_RESP;
                    else               idx_d   = idx_q + 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A bus error anywhere ends the sequence with an error response.
        if (cyc_q && wb_err_i) begin
            err_d   = 1'b1;
            dig_d   = '0;
            state_d = S_RESP;
        end

        rdy_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            blk_q   <= '0;
            nxt_q   <= 1'b0;
            dig_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef SHA_WBM_TIMEOUT_EN
            poll_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            blk_q   <= blk_d;
            nxt_q   <= nxt_d;
            dig_q   <= dig_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
`ifdef SHA_WBM_TIMEOUT_EN
            poll_q  <= poll_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha256_wb_master.sv
// Directed bench for sha256_wb_master against a behavioural Wishbone slave
// with programmable ack delay, ready/digest_valid timing and error injection.
module tb_sha256_wb_master;

    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] MID_DIG = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_next = 1'b0;
    logic [511:0] cmd_block = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [255:0] rsp_digest;
    logic         rsp_err;
    logic         busy;
    logic [31:0]  wb_adr_o, wb_dat_o;
    logic [3:0]   wb_sel_o;
    logic         wb_we_o, wb_cyc_o, wb_stb_o;
    logic [31:0]  s_dat;
    logic         s_ack, s_err;

    int total = 0;
    int bad = 0;

    // slave configuration, written only by the stimulus block
    int           ack_dly = 0;
    int           rdy_after = 2;
    int           dv_after = 1;
    logic         dv_stuck = 1'b0;
    logic         err_en = 1'b0;
    logic [31:0]  err_adr = 32'h14;
    logic [255:0] slv_digest = '0;

    // slave state and transfer log
    int           s_cnt, rd0_n, rd44_n;
    logic [31:0]  log_adr[$];
    logic [31:0]  log_dat[$];
    logic         log_we[$];
    int           mon_bad = 0;
    logic         p_cyc = 1'b0, p_ack = 1'b0, p_err = 1'b0, p_we = 1'b0;
    logic [31:0]  p_adr = '0, p_dat = '0;

    sha256_wb_master #(
        .BASE_ADDR (32'h0000_0000),
        .POLL_GAP  (2),
        .SETTLE_CYC(4),
        .TIMEOUT   (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_next  (cmd_next),
        .cmd_block (cmd_block),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_digest(rsp_digest),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_dat_i  (s_dat),
        .wb_ack_i  (s_ack),
        .wb_err_i  (s_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        logic [31:0] v;
        v = 32'hDEAD_0000;
        if (a == 32'h0)
            v = 32'hFFFF_FFFE | {31'd0, (rd0_n >= rdy_after)};
        else if (a == 32'h44)
            v = 32'hFFFF_FFFE | {31'd0, (!dv_stuck && rd44_n >= dv_after)};
        else if (a >= 32'h48 && a <= 32'h64)
            v = slv_digest[32*((a - 32'h48) >> 2) +: 32];
        return v;
    endfunction

    // Behavioural slave: one ack (or err) per transfer after ack_dly waits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack  <= 1'b0;
            s_err  <= 1'b0;
            s_cnt  <= 0;
            rd0_n  <= 0;
            rd44_n <= 0;
            s_dat  <= '0;
        end else begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                rd0_n  <= 0;
                rd44_n <= 0;
            end
            if (wb_cyc_o && wb_stb_o && !s_ack && !s_err) begin
                if (s_cnt >= ack_dly) begin
                    s_cnt <= 0;
                    log_adr.push_back(wb_adr_o);
                    log_dat.push_back(wb_dat_o);
                    log_we.push_back(wb_we_o);
                    if (err_en && wb_we_o && wb_adr_o == err_adr) s_err <= 1'b1;
                    else                                          s_ack <= 1'b1;
                    if (!wb_we_o) begin
                        s_dat <= rd_val(wb_adr_o);
                        if (wb_adr_o == 32'h0)  rd0_n  <= rd0_n + 1;
                        if (wb_adr_o == 32'h44) rd44_n <= rd44_n + 1;
                    end
                end else begin
                    s_cnt <= s_cnt + 1;
                end
            end
        end
    end

    // Bus protocol monitor: stb==cyc, sel constant, request held until
    // ack/err, cyc dropped on the cycle after ack/err.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_bad <= mon_bad
                + ((wb_stb_o !== wb_cyc_o || wb_sel_o !== 4'hF) ? 1 : 0)
                + ((p_cyc && (p_ack || p_err) && wb_cyc_o) ? 1 : 0)
                + ((p_cyc && !p_ack && !p_err && wb_cyc_o &&
                    {wb_adr_o, wb_dat_o, wb_we_o} !== {p_adr, p_dat, p_we}) ? 1 : 0);
        end
        p_cyc <= wb_cyc_o;
        p_ack <= s_ack;
        p_err <= s_err;
        p_adr <= wb_adr_o;
        p_dat <= wb_dat_o;
        p_we  <= wb_we_o;
    end

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int n_acc(input int from, input logic [31:0] a, input logic w);
        int n = 0;
        for (int j = from; j < log_adr.size(); j++)
            if (log_adr[j] == a && log_we[j] == w) n++;
        return n;
    endfunction

    function automatic int n_wr(input int from);
        int n = 0;
        for (int j = from; j < log_we.size(); j++)
            if (log_we[j]) n++;
        return n;
    endfunction

    task automatic check_writes(input int from, input logic [511:0] blk, input logic [31:0] ctl);
        int n = 0;
        for (int j = from; j < log_we.size(); j++) begin
            if (log_we[j]) begin
                if (n < 16)
                    check($sformatf("wr%0d", n), {log_adr[j], log_dat[j]},
                          {32'(4 * (n + 1)), blk[32*n +: 32]});
                else if (n == 16)
                    check("ctl_wr", {log_adr[j], log_dat[j]}, {32'h0, ctl});
                n++;
            end
        end
        check("n_writes", 320'(n), 320'd17);
    endtask

    task automatic send_cmd(input logic nxt, input logic [511:0] blk);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_next  = nxt;
        cmd_block = blk;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_next  = ~nxt;
        cmd_block = ~blk;
        check("accepted", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", rsp_valid, 1'b1);
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_released", {rsp_valid, cmd_ready, busy}, 3'b010);
    endtask

    logic [511:0] blk1, blk2a, blk2b;
    int           lstart, seen;

    initial begin
        blk1 = {32'h61626380, 448'd0, 32'h00000018};
        for (int i = 0; i < 16; i++) begin
            blk2a[32*i +: 32] = 32'hA100_0000 + 32'(i);
            blk2b[32*i +: 32] = 32'h5B00_0000 + 32'(i * 3);
        end

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outs", {cmd_ready, busy, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, rsp_digest},
              '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {cmd_ready, busy}, 2'b10);

        // 1: single init block, ready after two busy reads
        slv_digest = ABC_DIG;
        lstart = log_adr.size();
        send_cmd(1'b0, blk1);
        wait_rsp(1000);
        check("t1_digest", {rsp_err, rsp_digest}, {1'b0, ABC_DIG});
        check("t1_rdy_reads", 320'(n_acc(lstart, 32'h0, 1'b0)), 320'd3);
        check("t1_dv_reads", 320'(n_acc(lstart, 32'h44, 1'b0)), 320'd2);
        check_writes(lstart, blk1, 32'h1);
        accept_rsp();

        // 2: init then next
        slv_digest = MID_DIG;
        lstart = log_adr.size();
        send_cmd(1'b0, blk2a);
        wait_rsp(1000);
        check("t2a_digest", {rsp_err, rsp_digest}, {1'b0, MID_DIG});
        check_writes(lstart, blk2a, 32'h1);
        accept_rsp();
        slv_digest = TWO_DIG;
        lstart = log_adr.size();
        send_cmd(1'b1, blk2b);
        wait_rsp(1000);
        check("t2b_digest", {rsp_err, rsp_digest}, {1'b0, TWO_DIG});
        check_writes(lstart, blk2b, 32'h2);
        accept_rsp();

        // 3: slow slave, response held while rsp_ready low
        ack_dly = 3;
        slv_digest = ABC_DIG;
        lstart = log_adr.size();
        send_cmd(1'b0, blk1);
        wait_rsp(3000);
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin
                cmd_valid = 1'b1;
                cmd_block = blk2a;
            end
            check("t3_hold", {rsp_valid, cmd_ready, rsp_err, rsp_digest}, {1'b1, 1'b0, 1'b0, ABC_DIG});
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check_writes(lstart, blk1, 32'h1);
        accept_rsp();
        @(negedge clk);
        check("t3_no_new_cmd", busy, 1'b0);
        ack_dly = 0;

        // 4: bus error on the fifth block write
        err_en = 1'b1;
        err_adr = 32'h14;
        lstart = log_adr.size();
        send_cmd(1'b0, blk1);
        wait_rsp(1000);
        check("t4_err_rsp", {rsp_err, rsp_digest}, {1'b1, 256'd0});
        repeat (5) @(negedge clk);
        check("t4_quiet", {wb_cyc_o, rsp_valid}, 2'b01);
        check("t4_n_writes", 320'(n_wr(lstart)), 320'd5);
        check("t4_no_ctl", 320'(n_acc(lstart, 32'h0, 1'b1)), 320'd0);
        accept_rsp();
        err_en = 1'b0;

        // 5: digest_valid stuck low
        dv_stuck = 1'b1;
        lstart = log_adr.size();
        send_cmd(1'b0, blk1);
`ifdef SHA_WBM_TIMEOUT_EN
        wait_rsp(2000);
        check("t5_poll_reads", 320'(n_acc(lstart, 32'h44, 1'b0)), 320'd16);
        check("t5_timeout_rsp", {rsp_err, rsp_digest}, {1'b1, 256'd0});
        accept_rsp();
`else
        seen = 0;
        for (int c = 0; c < 4600; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("t5_no_rsp", 320'(seen), 320'd0);
        check("t5_polling", (n_acc(lstart, 32'h44, 1'b0) > 1000), 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
        dv_stuck = 1'b0;

        // 6: reset in the middle of the block writes, then repeat command 1
        lstart = log_adr.size();
        send_cmd(1'b0, blk1);
        seen = 0;
        while (n_wr(lstart) < 3 && seen < 500) begin
            @(negedge clk);
            seen++;
        end
        check("t6_in_wr_blk", (n_wr(lstart) >= 3), 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_abort", {wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready, busy}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        slv_digest = ABC_DIG;
        lstart = log_adr.size();
        send_cmd(1'b0, blk1);
        wait_rsp(1000);
        check("t6_digest", {rsp_err, rsp_digest}, {1'b0, ABC_DIG});
        check_writes(lstart, blk1, 32'h1);
        accept_rsp();

        check("bus_protocol", 320'(mon_bad), 320'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
